// File: rtl/pwm_generator_pkg.sv
// Shared definitions for the PWM generator: FSM state encoding and
// default widths for the period/duty counter and the dead-time counter.
package pwm_generator_pkg;

    localparam int CNT_W_DEFAULT  = 8;
    localparam int DEAD_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion between the PWM output and its complement.
// Only compiled when PWM_DEADTIME_EN is defined; otherwise the top drives
// a plain complementary pair and no dead-time logic exists.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime #(
    parameter int DEAD_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              level_i,
    input  logic [DEAD_W-1:0] dead_i,
    output logic              pwm_o,
    output logic              pwm_n_o
);

    logic              level_q;
    logic [DEAD_W-1:0] gap_cnt;
    logic              level_edge;
    logic              gap;

    // The edge cycle itself is the first gap cycle; the counter covers the
    // remaining dead_i-1 cycles, so the total gap is exactly dead_i.
    assign level_edge = (level_i != level_q);
    assign gap        = (level_edge && (dead_i != '0)) || (gap_cnt != '0);

    // Track the previous level and run the gap counter; a new edge reloads it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            gap_cnt <= '0;
        end else begin
            level_q <= level_i;
            if (level_edge) begin
                gap_cnt <= (dead_i == '0) ? '0 : dead_i - DEAD_W'(1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - DEAD_W'(1);
            end
        end
    end

    assign pwm_o   = en_i &  level_i & ~gap;
    assign pwm_n_o = en_i & ~level_i & ~gap;

endmodule
`endif

// File: rtl/pwm_generator.sv
// PWM generator with complementary output. Counts ticks derived from the
// rising edges of clk_div_i; period/duty are double-buffered and switch at
// the period wrap. Optional dead-time insertion: define PWM_DEADTIME_EN.
//
// load_i is a one-cycle strobe with no back-pressure: period_i/duty_i are
// valid in the cycle load_i is high and are always accepted in that cycle.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DEAD_W = DEAD_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              clk_div_i,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic [CNT_W-1:0]  duty_i,
    input  logic [DEAD_W-1:0] dead_i,
    output logic              pwm_o,
    output logic              pwm_n_o,
    output logic              period_end_o,
    output logic              busy_o
);

    pwm_state_e       state;
    pwm_state_e       state_next;
    logic             clk_div_q;
    logic             tick;
    logic             wrap;
    logic             run_next;
    logic             raw_pwm;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period_pend;
    logic [CNT_W-1:0] duty_pend;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] duty_nxt;
    logic             pwm_q;
    logic             period_end_q;

    assign tick     = clk_div_i & ~clk_div_q;
    assign wrap     = tick && (state != IDLE) && (count == period_act - CNT_W'(1));
    // A load landing on the wrapping tick takes effect at that very wrap.
    assign period_nxt = load_i ? period_i : period_pend;
    assign duty_nxt   = load_i ? duty_i   : duty_pend;
    assign raw_pwm  = (state != IDLE) && (count < duty_act);
    assign run_next = (state_next != IDLE);
    assign busy_o   = (state != IDLE);

    // Divided-clock edge detector.
    always_ff @(posedge clk_i) begin
        if (rst_i) clk_div_q <= 1'b0;
        else       clk_div_q <= clk_div_i;
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Next state; a zero period switched in at a wrap drops back to IDLE so
    // RUN never operates with a zero period.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable_i && (period_act != '0)) state_next = RUN;
            end
            RUN: begin
                if (wrap && (period_nxt == '0)) state_next = IDLE;
                else if (!enable_i)             state_next = DRAIN;
            end
            DRAIN: begin
                if (wrap && (period_nxt == '0)) state_next = IDLE;
                else if (enable_i)              state_next = RUN;
                else if (wrap)                  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending registers capture every load strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_pend <= '0;
            duty_pend   <= '0;
        end else if (load_i) begin
            period_pend <= period_i;
            duty_pend   <= duty_i;
        end
    end

    // Active registers follow pending while idle and switch at each wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_act <= '0;
            duty_act   <= '0;
        end else if (state == IDLE) begin
            period_act <= period_pend;
            duty_act   <= duty_pend;
        end else if (wrap) begin
            period_act <= period_nxt;
            duty_act   <= duty_nxt;
        end
    end

    // Tick counter: held at zero while idle, wraps at period_act-1.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state == IDLE)) count <= '0;
        else if (tick)                count <= wrap ? '0 : count + CNT_W'(1);
    end

    // Registered outputs, cleared on the same edge that enters IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            pwm_q        <= run_next & raw_pwm;
            period_end_q <= run_next & wrap;
        end
    end

    assign period_end_o = period_end_q;

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
        .DEAD_W (DEAD_W)
    ) u_deadtime (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (busy_o),
        .level_i (pwm_q),
        .dead_i  (dead_i),
        .pwm_o   (pwm_o),
        .pwm_n_o (pwm_n_o)
    );
`else
    logic pwm_n_q;
    logic unused_dead;

    assign unused_dead = ^dead_i;

    // Complement registered alongside pwm_q so both switch on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) pwm_n_q <= 1'b0;
        else       pwm_n_q <= run_next & ~raw_pwm;
    end

    assign pwm_o   = pwm_q;
    assign pwm_n_o = pwm_n_q;
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Testbench for pwm_generator. Builds with or without PWM_DEADTIME_EN.
module tb_pwm_generator;

    localparam int CNT_W  = 8;
    localparam int DEAD_W = 4;
    localparam int DIV    = 4;
`ifdef PWM_DEADTIME_EN
    localparam int DT = 3;
`else
    localparam int DT = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clk_div;
    logic              load;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  duty;
    logic [DEAD_W-1:0] dead;
    logic              pwm_o;
    logic              pwm_n_o;
    logic              period_end_o;
    logic              busy_o;

    int vectors = 0;
    int errors  = 0;

    // Reference model: pending and current (period, duty) per window.
    int pend_p = 0, pend_d = 0, cur_p = 0, cur_d = 0;
    int hi = 0, len = 0;
    bit prev_low = 1'b1;
    logic [31:0] exp_q[$];

    pwm_generator #(.CNT_W(CNT_W), .DEAD_W(DEAD_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .clk_div_i    (clk_div),
        .load_i       (load),
        .period_i     (period),
        .duty_i       (duty),
        .dead_i       (dead),
        .pwm_o        (pwm_o),
        .pwm_n_o      (pwm_n_o),
        .period_end_o (period_end_o),
        .busy_o       (busy_o)
    );

    // ---------------- clock / reset / divider ----------------
    always #5 clk = ~clk;

    initial begin
        int div_cnt;
        div_cnt = 0;
        clk_div = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div_cnt = (div_cnt + 1) % DIV;
            clk_div = (div_cnt < DIV / 2);
        end
    end

    // ---------------- expected value for one full period window ----------------
    function automatic logic [31:0] window_exp(input int p, input int d, input bit pl);
        int base;
        base = ((d >= p) ? p : d) * DIV;
        if (d > 0 && pl) base = base - DT;
        return {base[15:0], 16'(p * DIV)};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst || !busy_o) begin
            hi = 0; len = 0; prev_low = 1'b1;
            exp_q.delete();
            cur_p = pend_p; cur_d = pend_d;
            if (!rst) begin
                vectors++;
                if ({pwm_o, pwm_n_o, period_end_o} !== 3'b000) begin
                    errors++;
                    $display("FAIL idle_outputs: got %b expected 000", {pwm_o, pwm_n_o, period_end_o});
                end
            end
        end else begin
            hi += int'(pwm_o);
            len++;
            vectors++;
`ifdef PWM_DEADTIME_EN
            if (pwm_o && pwm_n_o) begin
                errors++;
                $display("FAIL overlap: pwm_o=1 and pwm_n_o=1 together");
            end
`else
            if (pwm_n_o !== ~pwm_o) begin
                errors++;
                $display("FAIL complement: pwm_o=%b pwm_n_o=%b", pwm_o, pwm_n_o);
            end
`endif
            if (period_end_o) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    vectors++;
                    if ({hi[15:0], len[15:0]} !== e) begin
                        errors++;
                        $display("FAIL window: high=%0d len=%0d expected high=%0d len=%0d",
                                 hi, len, e[31:16], e[15:0]);
                    end
                end
                prev_low = (cur_d < cur_p);
                cur_p = pend_p; cur_d = pend_d;
                exp_q.push_back(window_exp(cur_p, cur_d, prev_low));
                hi = 0; len = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues a load in the current cycle (caller is at posedge+1).
    task automatic do_load(input int p, input int d);
        load = 1'b1; period = CNT_W'(p); duty = CNT_W'(d);
        pend_p = p; pend_d = d;
        step(1);
        load = 1'b0;
    endtask

    // Returns at the negedge of the cycle where period_end_o is high.
    task automatic wait_pulse();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (period_end_o) break;
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL wait_pulse: no period_end_o within 200 cycles");
                break;
            end
        end
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge clk);
            h += int'(pwm_o);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load = 1'b0; period = '0; duty = '0; dead = 4'd3;
        step(3);
        @(negedge clk);
        vectors += 4;
        if (pwm_o !== 1'b0)        begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm_o); end
        if (pwm_n_o !== 1'b0)      begin errors++; $display("FAIL reset_pwm_n: got %b expected 0", pwm_n_o); end
        if (period_end_o !== 1'b0) begin errors++; $display("FAIL reset_end: got %b expected 0", period_end_o); end
        if (busy_o !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        step(1);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        int h;
        do_load(10, 3);
        step(3);
        enable = 1'b1;
        repeat (3) wait_pulse();
        count_high(40, h);
        vectors++;
        if (h !== 12 - DT) begin errors++; $display("FAIL basic_high: got %0d expected %0d", h, 12 - DT); end
        repeat (2) wait_pulse();
    endtask

    task automatic test_duty_extremes();
        int h;
        step(1);
        do_load(10, 0);
        repeat (2) wait_pulse();
        count_high(40, h);
        vectors++;
        if (h !== 0) begin errors++; $display("FAIL duty0_high: got %0d expected 0", h); end
        step(1);
        do_load(10, 12);
        repeat (2) wait_pulse();
        count_high(40, h);
        vectors++;
        if (h !== 40) begin errors++; $display("FAIL duty12_high: got %0d expected 40", h); end
    endtask

    task automatic test_mid_load();
        int h;
        step(1);
        do_load(10, 3);
        repeat (2) wait_pulse();
        step(11);
        do_load(10, 7);
        wait_pulse();
        count_high(40, h);
        vectors++;
        if (h !== 28 - DT) begin errors++; $display("FAIL mid_load_high: got %0d expected %0d", h, 28 - DT); end
        // Load exactly on the wrapping tick cycle: applies at that wrap.
        wait_pulse();
        step(39);
        do_load(10, 2);
        wait_pulse();
        count_high(40, h);
        vectors++;
        if (h !== 8 - DT) begin errors++; $display("FAIL wrap_load_high: got %0d expected %0d", h, 8 - DT); end
    endtask

    task automatic test_random_loads();
        int p, d, k;
        for (int i = 0; i < 12; i++) begin
            p = $urandom_range(1, 12);
            d = $urandom_range(0, 14);
            wait_pulse();
            step(1);
            k = $urandom_range(0, cur_p * DIV - 2);
            step(k);
            do_load(p, d);
        end
        repeat (2) wait_pulse();
    endtask

    task automatic test_drain();
        step(1);
        do_load(10, 3);
        repeat (2) wait_pulse();
        wait_pulse();
        step(17);
        enable = 1'b0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            vectors++;
            if (busy_o !== 1'b1) begin errors++; $display("FAIL drain_busy: cycle %0d got %b expected 1", i, busy_o); end
            step(1);
        end
        @(negedge clk);
        vectors++;
        if ({busy_o, pwm_o, pwm_n_o, period_end_o} !== 4'b0000) begin
            errors++;
            $display("FAIL drain_idle: got %b expected 0000", {busy_o, pwm_o, pwm_n_o, period_end_o});
        end
        step(3);
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        repeat (2) wait_pulse();
        step(20);
        rst = 1'b1;
        pend_p = 0; pend_d = 0;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy_o, pwm_o, pwm_n_o, period_end_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 0000", {busy_o, pwm_o, pwm_n_o, period_end_o});
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy_o, period_end_o} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_hold: cycle %0d got %b expected 00", i, {busy_o, period_end_o});
            end
        end
        step(1);
        enable = 1'b0;
        step(2);
    endtask

    task automatic test_period_zero();
        do_load(0, 5);
        step(3);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (busy_o !== 1'b0) begin errors++; $display("FAIL period_zero: cycle %0d busy got %b expected 0", i, busy_o); end
        end
        step(1);
        enable = 1'b0;
        step(2);
    endtask

`ifdef PWM_DEADTIME_EN
    task automatic test_deadtime();
        int g, n;
        do_load(10, 3);
        step(3);
        enable = 1'b1;
        repeat (2) wait_pulse();
        // pwm_o falling -> pwm_n_o rising
        n = 0;
        do begin @(negedge clk); n++; end while (!pwm_o && n < 100);
        do begin @(negedge clk); n++; end while (pwm_o && n < 200);
        g = 0;
        while (!pwm_n_o && g < 20) begin g++; @(negedge clk); end
        vectors++;
        if (g !== 3) begin errors++; $display("FAIL dead_fall: gap got %0d expected 3", g); end
        // pwm_n_o falling -> pwm_o rising
        n = 0;
        do begin @(negedge clk); n++; end while (pwm_n_o && n < 100);
        g = 0;
        while (!pwm_o && g < 20) begin g++; @(negedge clk); end
        vectors++;
        if (g !== 3) begin errors++; $display("FAIL dead_rise: gap got %0d expected 3", g); end
        step(1);
        enable = 1'b0;
        repeat (2) wait_pulse();
        step(4);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_duty_extremes();
        test_mid_load();
        test_random_loads();
        test_drain();
        test_reset_mid();
        test_period_zero();
`ifdef PWM_DEADTIME_EN
        test_deadtime();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of period/duty/counter.
REQ-002 SHALL have parameter DEAD_W, default 4, meaning width of dead-time count in clk_i cycles.
REQ-003 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable_i  input  1  run request.
REQ-006 SHALL have port clk_div_i  input  1  divided clock from upstream clock divider, same clk_i domain, used as tick source only (never as a clock).
REQ-007 SHALL have port load_i  input  1  one-cycle strobe capturing period_i/duty_i.
REQ-008 SHALL have port period_i  input  CNT_W  PWM period in ticks.
REQ-009 SHALL have port duty_i  input  CNT_W  high time in ticks.
REQ-010 SHALL have port dead_i  input  DEAD_W  dead time in clk_i cycles.
REQ-011 SHALL have port pwm_o  output  1  PWM output.
REQ-012 SHALL have port pwm_n_o  output  1  complementary PWM output.
REQ-013 SHALL have port period_end_o  output  1  one-cycle pulse at each period wrap.
REQ-014 SHALL have port busy_o  output  1  high in RUN or DRAIN.

Function
REQ-015 SHALL register clk_div_i once (clk_div_q); tick = clk_div_i & ~clk_div_q, one clk_i cycle wide per divided-clock rising edge.
REQ-016 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN when enable_i=1 and active period != 0; RUN->DRAIN when enable_i=0; DRAIN->RUN if enable_i returns before wrap; DRAIN->IDLE on wrap; RUN with active period 0 never entered.
REQ-017 SHALL hold counter at 0 in IDLE; in RUN/DRAIN increment on tick, wrap to 0 on tick when count == period_act-1.
REQ-018 SHALL pulse period_end_o for exactly one cycle, the cycle after the wrapping tick.
REQ-019 SHALL capture period_i/duty_i into pending registers on load_i; pending copied to active at next wrap, or on the next cycle when in IDLE.
REQ-020 SHALL, when load_i coincides with a wrapping tick, apply the newly loaded values at that wrap.
REQ-021 SHALL drive raw pwm = (count < duty_act) in RUN/DRAIN, 0 in IDLE; duty_act >= period_act gives constant high, duty_act = 0 gives constant low.
REQ-022 SHALL register pwm_o from raw pwm: pwm_o reflects a counter change one clk_i cycle after the counter updates (two cycles after clk_div_i is first sampled high).
REQ-023 SHALL keep pwm_o, pwm_n_o, period_end_o at 0 in IDLE.
REQ-024 SHALL ignore ticks while in IDLE.

Reset
REQ-025 SHALL on rst_i=1 set FSM to IDLE, counter, pending and active registers, clk_div_q, dead-time counter and all outputs to 0.
REQ-026 SHALL let rst_i mid-period abort immediately with no period_end_o pulse; rst_i has priority over load_i and enable_i.

Configuration
REQ-027 SHALL use macro PWM_DEADTIME_EN.
REQ-028 SHALL with PWM_DEADTIME_EN defined: on each raw pwm edge force pwm_o=pwm_n_o=0 for dead_i clk_i cycles, then assert the newly active output; dead_i=0 means no gap; a new edge during the gap restarts it.
REQ-029 SHALL without PWM_DEADTIME_EN: pwm_n_o = ~pwm_o in RUN/DRAIN, 0 in IDLE; dead_i ignored; no dead-time logic present.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, RUN, DRAIN) and default CNT_W/DEAD_W constants in shared package pwm_generator_pkg.
REQ-031 SHALL isolate dead-time insertion in sub-module pwm_deadtime, instantiated only under PWM_DEADTIME_EN.

Verification
REQ-032 SHALL cover: DIV=4 divider feeding clk_div_i, load period=10 duty=3, enable -> pwm_o high 3 of every 10 ticks, period_end_o every 40 clk_i cycles.
REQ-033 SHALL cover: duty=0 then duty=12 with period=10 -> pwm_o constant 0, then constant 1 after next wrap.
REQ-034 SHALL cover: load duty=7 mid-period -> old duty holds until wrap, 7 applies from next period; load on wrapping tick applies immediately.
REQ-035 SHALL cover: enable_i dropped at count 4 of period 10 -> busy_o stays 1 until wrap, then IDLE, all outputs 0.
REQ-036 SHALL cover: rst_i at count 5 -> next cycle outputs 0, counter 0, IDLE, no period_end_o.
REQ-037 SHALL cover: PWM_DEADTIME_EN, dead_i=3 -> both outputs low exactly 3 cycles at each edge; period=0 load -> stays IDLE.
